// File: rtl/rr_priority_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rr_priority_arbiter_pkg
//   Shared constants and types for the rotating-priority arbiter.
//   ARB_N       : default number of requesters.
//   arb_vec_t   : one bit per requester.
//   arb_out_t   : registered result as observed at the boundary,
//                 packed as {any_grant, grant}.
// ---------------------------------------------------------------------------
package rr_priority_arbiter_pkg;

    localparam int ARB_N = 128;

    typedef logic [ARB_N-1:0] arb_vec_t;

    typedef struct packed {
        logic     any_grant;
        arb_vec_t grant;
    } arb_out_t;

endpackage : rr_priority_arbiter_pkg

// File: rtl/rr_priority_arbiter_find_first_wrap.sv
// ---------------------------------------------------------------------------
// rr_find_first_wrap
//   Purely combinational search for the first set bit of req at or above
//   the one-hot start position, wrapping back to bit 0 when nothing at or
//   above start is set.
//
//   Ports:
//     req    [N-1:0]  in   request vector
//     start  [N-1:0]  in   one-hot start position (must be exactly one-hot)
//     select [N-1:0]  out  one-hot winner, zero when req is zero
//     found           out  1 when any request is present
// ---------------------------------------------------------------------------
module rr_find_first_wrap
    import rr_priority_arbiter_pkg::*;
#(
    parameter int N = ARB_N
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] start,
    output logic [N-1:0] select,
    output logic         found
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] mask_ge;
    logic [N-1:0] upper;

    always_comb begin
        // For a one-hot start at bit s, start-1 sets exactly the bits below
        // s, so its complement selects bits s..N-1.
        mask_ge = ~(start - ONE);
        upper   = req & mask_ge;
        // x & -x isolates the lowest set bit. Prefer the upper half of the
        // ring; fall back to the whole vector, which is the wrap-around case.
        if (|upper) begin
            select = upper & (~upper + ONE);
        end else begin
            select = req & (~req + ONE);
        end
        found = |req;
    end

endmodule : rr_find_first_wrap

// File: rtl/rr_priority_arbiter.sv
// ---------------------------------------------------------------------------
// rr_priority_arbiter
//   Rotating-priority arbiter with registered one-hot grant. The caller
//   owns the rotation policy; this block never changes prio itself.
//   There is no handshake: every cycle's req/prio produces a grant on the
//   following clock edge.
//
//   Ports:
//     clk        in   rising-edge clock
//     rst        in   synchronous active-high reset, clears grant/any_grant
//     prio  [N]  in   one-hot start index; lowest set bit wins, zero -> 0
//     req   [N]  in   request vector
//     grant [N]  out  registered one-hot grant, zero when idle
//     any_grant  out  registered, equals |grant
// ---------------------------------------------------------------------------
module rr_priority_arbiter
    import rr_priority_arbiter_pkg::*;
#(
    parameter int N = ARB_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] prio,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic         any_grant
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] prio_lowest;
    logic [N-1:0] start;
    logic [N-1:0] next_grant;
    logic         next_any;

    // Reduce prio to a clean one-hot so the finder's masking stays valid
    // even when a caller drives stray extra bits or no bits at all.
    always_comb begin
        prio_lowest = prio & (~prio + ONE);
        start       = (|prio) ? prio_lowest : ONE;
    end

    rr_find_first_wrap #(
        .N (N)
    ) u_find (
        .req    (req),
        .start  (start),
        .select (next_grant),
        .found  (next_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            grant     <= '0;
            any_grant <= 1'b0;
        end else begin
            grant     <= next_grant;
            any_grant <= next_any;
        end
    end

endmodule : rr_priority_arbiter

// File: tb/tb_rr_priority_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_priority_arbiter
//   Self-checking bench. Expected results come from a ring-scan model that
//   walks indices s, s+1, ... modulo N and are queued in exp_q one cycle
//   ahead of the registered DUT output.
// ---------------------------------------------------------------------------
module tb_rr_priority_arbiter;
    import rr_priority_arbiter_pkg::*;

    localparam int N = ARB_N;
    typedef logic [N:0] obs_t;

    // ---------------- clock / reset ----------------
    logic         clk;
    logic         rst;
    logic [N-1:0] prio;
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic         any_grant;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    rr_priority_arbiter #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .prio      (prio),
        .req       (req),
        .grant     (grant),
        .any_grant (any_grant)
    );

    // ---------------- scoreboard state ----------------
    obs_t exp_q[$];
    int   tests_run;
    int   tests_failed;
    logic [N-1:0] prev_req;

    // ---------------- reference model ----------------
    function automatic logic [N-1:0] bit_at(input int k);
        logic [N-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    function automatic obs_t model(input logic [N-1:0] p, input logic [N-1:0] r);
        int   s;
        int   idx;
        obs_t res;
        s = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (p[i]) s = i;
        end
        res = '0;
        for (int k = 0; k < N; k++) begin
            idx = (s + k) % N;
            if (r[idx]) begin
                res[idx] = 1'b1;
                res[N]   = 1'b1;
                break;
            end
        end
        return res;
    endfunction

    function automatic int popcount(input logic [N-1:0] v);
        int c;
        c = 0;
        for (int i = 0; i < N; i++) c += int'(v[i]);
        return c;
    endfunction

    // ---------------- driver tasks ----------------
    // Drive one cycle of inputs, queue its expected result, advance past the
    // capturing edge. Inputs change #1 after the edge, outputs are sampled there.
    task automatic drive(input logic [N-1:0] p, input logic [N-1:0] r);
        prio     = p;
        req      = r;
        exp_q.push_back(model(p, r));
        prev_req = r;
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        obs_t obs;
        obs_t exp;
        rst  = 1'b1;
        prio = bit_at(5);
        req  = '1;
        @(posedge clk);
        #1;
        obs = {any_grant, grant};
        if (obs !== obs_t'(0)) begin
            $display("FAIL reset_clear: got %h want %h", obs, obs_t'(0));
            tests_failed++;
        end
        tests_run++;
        rst = 1'b0;
        drive(bit_at(5), '1);
        exp = exp_q.pop_front();
        obs = {any_grant, grant};
        if (obs !== exp || exp !== {1'b1, bit_at(5)}) begin
            $display("FAIL reset_release: got %h want %h", obs, {1'b1, bit_at(5)});
            tests_failed++;
        end
        tests_run++;
    endtask

    task automatic test_directed();
        logic [N-1:0] p_tab[6];
        logic [N-1:0] r_tab[6];
        logic [N-1:0] g_tab[6];
        obs_t obs;
        obs_t exp;
        // direct hit, direct hit high, forward skip, two wraps, idle
        p_tab[0] = bit_at(0);   r_tab[0] = bit_at(0)  | bit_at(64); g_tab[0] = bit_at(0);
        p_tab[1] = bit_at(64);  r_tab[1] = bit_at(0)  | bit_at(64); g_tab[1] = bit_at(64);
        p_tab[2] = bit_at(1);   r_tab[2] = bit_at(0)  | bit_at(64); g_tab[2] = bit_at(64);
        p_tab[3] = bit_at(100); r_tab[3] = bit_at(35) | bit_at(99); g_tab[3] = bit_at(35);
        p_tab[4] = bit_at(127); r_tab[4] = bit_at(0)  | bit_at(64); g_tab[4] = bit_at(0);
        p_tab[5] = bit_at(77);  r_tab[5] = '0;                      g_tab[5] = '0;
        for (int t = 0; t < 6; t++) begin
            drive(p_tab[t], r_tab[t]);
            exp = exp_q.pop_front();
            obs = {any_grant, grant};
            if (obs !== {(|g_tab[t]), g_tab[t]} || exp !== {(|g_tab[t]), g_tab[t]}) begin
                $display("FAIL directed_%0d: got %h want %h", t, obs, {(|g_tab[t]), g_tab[t]});
                tests_failed++;
            end
            tests_run++;
        end
        // all requests, zero prio (s=0), multi-bit prio (lowest wins)
        drive(bit_at(90), '1);
        obs = {any_grant, grant};
        exp = exp_q.pop_front();
        if (obs !== {1'b1, bit_at(90)}) begin
            $display("FAIL all_req: got %h want %h", obs, {1'b1, bit_at(90)});
            tests_failed++;
        end
        tests_run++;
        drive('0, bit_at(3) | bit_at(120));
        obs = {any_grant, grant};
        exp = exp_q.pop_front();
        if (obs !== {1'b1, bit_at(3)}) begin
            $display("FAIL zero_prio: got %h want %h", obs, {1'b1, bit_at(3)});
            tests_failed++;
        end
        tests_run++;
        drive(bit_at(50) | bit_at(10), bit_at(5) | bit_at(20) | bit_at(60));
        obs = {any_grant, grant};
        exp = exp_q.pop_front();
        if (obs !== {1'b1, bit_at(20)}) begin
            $display("FAIL multi_prio: got %h want %h", obs, {1'b1, bit_at(20)});
            tests_failed++;
        end
        tests_run++;
    endtask

    task automatic test_sweep();
        obs_t         obs;
        obs_t         exp;
        logic [N-1:0] r;
        logic [N-1:0] sampled;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N / 2; j++) begin
                for (int ph = 0; ph < 2; ph++) begin
                    r = (ph == 0) ? (bit_at(j) | bit_at(j + N / 2)) : '0;
                    drive(bit_at(k), r);
                    sampled = prev_req;
                    exp = exp_q.pop_front();
                    obs = {any_grant, grant};
                    if (obs !== exp) begin
                        $display("FAIL sweep k=%0d j=%0d ph=%0d: got %h want %h", k, j, ph, obs, exp);
                        tests_failed++;
                    end
                    tests_run++;
                    if (popcount(grant) > 1 || (grant & ~sampled) != '0 || any_grant !== (|grant)) begin
                        $display("FAIL sweep_invariant k=%0d j=%0d: grant %h any %b req %h", k, j, grant, any_grant, sampled);
                        tests_failed++;
                    end
                    tests_run++;
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t         obs;
        obs_t         exp;
        logic [N-1:0] p;
        logic [N-1:0] r;
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 9))
                0:       p = '0;
                1:       p = bit_at($urandom_range(0, N - 1)) | bit_at($urandom_range(0, N - 1));
                default: p = bit_at($urandom_range(0, N - 1));
            endcase
            r = '0;
            case ($urandom_range(0, 3))
                0: r = '0;
                1: r = '1;
                default: begin
                    for (int b = 0; b < int'($urandom_range(1, 6)); b++) begin
                        r[$urandom_range(0, N - 1)] = 1'b1;
                    end
                end
            endcase
            drive(p, r);
            exp = exp_q.pop_front();
            obs = {any_grant, grant};
            if (obs !== exp) begin
                $display("FAIL random n=%0d: got %h want %h", n, obs, exp);
                tests_failed++;
            end
            tests_run++;
        end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        prio         = '0;
        req          = '0;
        prev_req     = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_directed();
        test_sweep();
        test_back_to_back();
        // reset again mid-traffic must clear outputs
        rst  = 1'b1;
        prio = bit_at(9);
        req  = '1;
        @(posedge clk);
        #1;
        if ({any_grant, grant} !== obs_t'(0)) begin
            $display("FAIL reset_override: got %h want %h", {any_grant, grant}, obs_t'(0));
            tests_failed++;
        end
        tests_run++;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_rr_priority_arbiter

// File: doc/rr_priority_arbiter.md
Name: rr_priority_arbiter

Overview:
- 128-way rotating-priority arbiter.
- A one-hot priority vector selects the starting index. The block grants exactly one requester: the first asserted request at or after that index, scanning upward with wrap-around.
- Outputs are registered. The block sits between request sources and a shared resource, and produces a one-hot grant plus an any-grant flag.
- Verification observes the 129-bit concatenation {any_grant, grant}.

Parameters:
- N, 128, number of requesters; must be ≥2. Port widths scale with N.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- priority  input  N  one-hot start index; bit k set means index k has highest priority this cycle
- req  input  N  request vector; bit i set means requester i wants the resource
- grant  output  N  registered one-hot grant; all zero when nothing is granted
- any_grant  output  1  registered; 1 when any bit of grant is 1

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: on a rising clk edge with rst=1, grant and any_grant are set to 0. Reset overrides any request in the same cycle.
- Start index s:
  - s = index of the lowest set bit of priority.
  - If priority is all zero, s = 0.
  - Extra set bits above the lowest are ignored. Callers are required to drive priority one-hot.
- Grant selection, combinational, from the current cycle's req and priority:
  - Scan indices s, s+1, …, N-1, 0, 1, …, s-1.
  - The first index i with req[i]=1 gets next_grant[i]=1. All other bits of next_grant are 0.
  - If req is all zero, next_grant = 0.
- any_grant_next = OR of req. This is equivalent to OR of next_grant.
- Latency: exactly 1 cycle. grant and any_grant update on the clk edge after the inputs are sampled. There is no handshake and no internal state beyond the output registers.
- Priority is not auto-rotated: the grant never updates priority internally. Any rotation policy belongs to the caller.
- Invariants, every cycle after reset:
  - grant is zero or one-hot.
  - any_grant == |grant.
  - grant is a subset of the req sampled on the previous cycle.
- Boundary cases:
  - req[s]=1 → grant[s].
  - Only indices below s requested → wrap-around; grant goes to the lowest requested index.
  - s = N-1 → search wraps immediately after N-1.
  - All requests set → grant[s].
- Suggested implementation: double-width thermometer/subtract trick, or a parallel-prefix "found" chain over the rotated vector. A linear chain is acceptable if it meets timing.

Decomposition:
- Shared package: constant ARB_N = 128; typedef arb_vec_t = logic [ARB_N-1:0].
- One natural sub-module: rr_find_first_wrap. It is purely combinational: inputs req, start one-hot; output one-hot select plus found. The top level adds the priority normalisation (lowest-set-bit) and the output registers.

Test Plan:
- Reset: rst=1 with req=all ones, priority=1<<5 → after the edge, {any_grant, grant} = 129'h0. Release rst → the next cycle shows grant = 1<<5, any_grant=1.
- Direct hit: priority=1<<0, req=(1<<0)|(1<<64) → next cycle grant=1<<0, any_grant=1. With priority=1<<64 and the same req → grant=1<<64.
- Forward skip: priority=1<<1, req=(1<<0)|(1<<64) → grant=1<<64.
- Wrap-around:
  - priority=1<<100, req=(1<<35)|(1<<99) → grant=1<<35.
  - priority=1<<127, req=(1<<0)|(1<<64) → grant=1<<0.
- Idle: any priority, req=0 → grant=0, any_grant=0 one cycle later.
- Exhaustive sweep: for every k in 0..127 set priority=1<<k. For each j in 0..63 apply req=(1<<j)|(1<<(j+64)), then req=0. Compare each cycle against a reference model and check the one-hot and subset invariants.
